// File: rtl/sort_select_pipe.sv
// sort_select_pipe: N-stage odd-even transposition sorter with a per-beat
// rank select on the output. Each compare layer is followed by a register
// layer. One global enable stalls the whole pipe, and bubbles travel with
// their slots.

// Single compare-exchange lane: the smaller value goes to lo. On a tie no
// swap is made, so the original order is kept.
module sort_cmpx #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;

  // Swap only when the upper element is strictly smaller.
  always_comb begin
    swap = (b < a);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

module sort_select_pipe #(
  parameter int WIDTH = 8,
  parameter int N     = 7,
  parameter int RW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [RW-1:0]        in_rank,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [N*WIDTH-1:0]   out_sorted
);

  // One pipeline slot: the partially sorted vector plus the rank that
  // travels with it. The packed data layout matches the flat port layout.
  typedef struct packed {
    logic [N-1:0][WIDTH-1:0] data;
    logic [RW-1:0]           rank;
  } beat_t;

  beat_t           stg [1:N];
  logic [N:1]      vld_pipe;
  logic            en;

  // lin[s] feeds compare layer s, and lout[s] is that layer's result.
  logic [WIDTH-1:0] lin  [N][N];
  logic [WIDTH-1:0] lout [N][N];

  assign en       = !vld_pipe[N] || out_ready;
  assign in_ready = en;

  // Layer 0 reads the input beat. Layer s reads stage s.
  for (genvar s = 0; s < N; s++) begin : g_src
    for (genvar i = 0; i < N; i++) begin : g_el
      if (s == 0) begin : g_in
        assign lin[s][i] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_stg
        assign lin[s][i] = stg[s].data[i];
      end
    end
  end

  // Even layers pair (0,1),(2,3),... and odd layers pair (1,2),(3,4),...
  // An element that is left out of a pair passes straight through.
  for (genvar s = 0; s < N; s++) begin : g_lay
    for (genvar i = 0; i < N; i++) begin : g_el
      if (((i % 2) == (s % 2)) && (i + 1 < N)) begin : g_cx
        sort_cmpx #(.WIDTH(WIDTH)) u_cx (
          .a  (lin[s][i]),
          .b  (lin[s][i+1]),
          .lo (lout[s][i]),
          .hi (lout[s][i+1])
        );
      end else if (!((i >= 1) && (((i - 1) % 2) == (s % 2)))) begin : g_pass
        assign lout[s][i] = lin[s][i];
      end
    end
  end

  // Stage registers and the valid shift chain. All of them advance together
  // on en. Reset clears everything and wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 1; k <= N; k++) stg[k] <= '0;
    end else if (en) begin
      vld_pipe     <= {vld_pipe[N-1:1], in_valid};
      stg[1].rank  <= in_rank;
      for (int i = 0; i < N; i++) stg[1].data[i] <= lout[0][i];
      for (int k = 2; k <= N; k++) begin
        stg[k].rank <= stg[k-1].rank;
        for (int i = 0; i < N; i++) stg[k].data[i] <= lout[k-1][i];
      end
    end
  end

  assign out_valid  = vld_pipe[N];
  assign out_sorted = stg[N].data;

  // Rank mux. Any rank with no matching index (rank >= N) falls to the
  // default, which is the maximum element.
  always_comb begin
    out_data = stg[N].data[N-1];
    for (int i = 0; i < N - 1; i++) begin
      if (stg[N].rank == RW'(i)) out_data = stg[N].data[i];
    end
  end

endmodule

// File: tb/tb_sort_select_pipe.sv
module tb_sort_select_pipe;
  typedef struct {
    logic [255:0] s;
    logic [15:0]  d;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv7, ird7, ov7, ordy7;
  logic [55:0] idat7, osort7;
  logic [2:0]  irank7;
  logic [7:0]  odat7;
  logic ivb, irdb, ovb, ordyb;
  logic [47:0] idatb, osortb;
  logic [1:0]  irankb;
  logic [11:0] odatb;
  logic ivc, irdc, ovc, ordyc;
  logic [1:0]  idatc, osortc;
  logic        irankc;
  logic        odatc;

  sort_select_pipe #(.WIDTH(8), .N(7)) u_d7 (
    .clk(clk), .rst(rst), .in_valid(iv7), .in_ready(ird7), .in_data(idat7),
    .in_rank(irank7), .out_valid(ov7), .out_ready(ordy7), .out_data(odat7),
    .out_sorted(osort7));
  sort_select_pipe #(.WIDTH(12), .N(4)) u_db (
    .clk(clk), .rst(rst), .in_valid(ivb), .in_ready(irdb), .in_data(idatb),
    .in_rank(irankb), .out_valid(ovb), .out_ready(ordyb), .out_data(odatb),
    .out_sorted(osortb));
  sort_select_pipe #(.WIDTH(1), .N(2)) u_dc (
    .clk(clk), .rst(rst), .in_valid(ivc), .in_ready(irdc), .in_data(idatc),
    .in_rank(irankc), .out_valid(ovc), .out_ready(ordyc), .out_data(odatc),
    .out_sorted(osortc));

  exp_t q7[$], qb[$], qc[$];

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic exp_t model(logic [255:0] din, int unsigned r, int n, int w);
    int unsigned v[16];
    int unsigned t, mask, idx;
    int j;
    exp_t e;
    mask = (1 << w) - 1;
    for (int i = 0; i < n; i++) v[i] = int'(din >> (i * w)) & mask;
    for (int i = 1; i < n; i++) begin
      t = v[i];
      j = i - 1;
      while (j >= 0 && v[j] > t) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = t;
    end
    idx = (r >= n) ? n - 1 : r;
    e.s = '0;
    for (int i = 0; i < n; i++) e.s = e.s | (256'(v[i]) << (i * w));
    e.d = 16'(v[idx]);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q7.delete(); qb.delete(); qc.delete();
    end else begin
      if (ov7 && ordy7) begin
        chk("d7_expected_beat", q7.size() != 0);
        if (q7.size() != 0) begin
          e = q7.pop_front();
          chk("d7_out_data", odat7 === e.d[7:0]);
          chk("d7_out_sorted", osort7 === e.s[55:0]);
        end
      end
      if (iv7 && ird7) q7.push_back(model(256'(idat7), irank7, 7, 8));
      if (ovb && ordyb) begin
        chk("db_expected_beat", qb.size() != 0);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("db_out_data", odatb === e.d[11:0]);
          chk("db_out_sorted", osortb === e.s[47:0]);
        end
      end
      if (ivb && irdb) qb.push_back(model(256'(idatb), irankb, 4, 12));
      if (ovc && ordyc) begin
        chk("dc_expected_beat", qc.size() != 0);
        if (qc.size() != 0) begin
          e = qc.pop_front();
          chk("dc_out_data", odatc === e.d[0]);
          chk("dc_out_sorted", osortc === e.s[1:0]);
        end
      end
      if (ivc && irdc) qc.push_back(model(256'(idatc), irankc, 2, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send7(input logic [55:0] d, input logic [2:0] r);
    bit acc;
    int n;
    iv7 = 1'b1; idat7 = d; irank7 = r; n = 0;
    #1;
    do begin
      acc = ird7;
      tick();
      n++;
    end while (!acc && n < 50);
    chk("send7_accept", acc === 1'b1);
    iv7 = 1'b0;
  endtask

  task automatic wait_ov7(output int n);
    n = 0;
    while (!ov7 && n < 30) begin
      tick();
      n++;
    end
    chk("wait_ov7", ov7 === 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q7.size() != 0 || qb.size() != 0 || qc.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", (q7.size() + qb.size() + qc.size()) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    logic [7:0]  held;
    logic [55:0] helds;
    logic [55:0] bd[10];
    logic [2:0]  br[10];

    rst = 1'b1;
    iv7 = 0; ordy7 = 1; idat7 = '0; irank7 = '0;
    ivb = 0; ordyb = 1; idatb = '0; irankb = '0;
    ivc = 0; ordyc = 1; idatc = '0; irankc = '0;
    repeat (3) tick();
    chk("rst_out_valid", ov7 === 1'b0);
    chk("rst_out_data", odat7 === 8'd0);
    chk("rst_out_sorted", osort7 === 56'd0);
    chk("rst_db_valid", ovb === 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", ird7 === 1'b1);

    send7({8'd6, 8'd5, 8'd40, 8'd30, 8'd2, 8'd1, 8'd0}, 3'd3);
    wait_ov7(n);
    chk("t1_latency", n == 6);
    chk("t1_out_data", odat7 === 8'd5);
    chk("t1_out_sorted", osort7 === {8'd40, 8'd30, 8'd6, 8'd5, 8'd2, 8'd1, 8'd0});
    tick();

    send7({8'd6, 8'd5, 8'd40, 8'd30, 8'd2, 8'd1, 8'd0}, 3'd0);
    send7({8'd6, 8'd5, 8'd40, 8'd30, 8'd2, 8'd1, 8'd0}, 3'd6);
    send7({8'd6, 8'd5, 8'd40, 8'd30, 8'd2, 8'd1, 8'd0}, 3'd7);
    wait_ov7(n);
    chk("t2_rank0", odat7 === 8'd0);
    tick();
    chk("t2_valid2", ov7 === 1'b1);
    chk("t2_rank6", odat7 === 8'd40);
    tick();
    chk("t2_valid3", ov7 === 1'b1);
    chk("t2_rank7_clamp", odat7 === 8'd40);
    tick();
    chk("t2_valid_end", ov7 === 1'b0);

    send7({8'd0, 8'd10, 8'd50, 8'd100, 8'd150, 8'd200, 8'd255}, 3'd3);
    send7({7{8'd255}}, 3'd3);
    wait_ov7(n);
    chk("t3_rev_data", odat7 === 8'd100);
    chk("t3_rev_sorted", osort7 === {8'd255, 8'd200, 8'd150, 8'd100, 8'd50, 8'd10, 8'd0});
    tick();
    chk("t3_eq_data", odat7 === 8'd255);
    chk("t3_eq_sorted", osort7 === {7{8'd255}});
    tick();

    for (int j = 0; j < 10; j++) begin
      bd[j] = {$urandom, $urandom};
      br[j] = 3'($urandom_range(0, 7));
    end
    for (int j = 0; j < 10; j++) begin
      if (j == 8) begin
        ordy7 = 1'b0; iv7 = 1'b1; idat7 = bd[j]; irank7 = br[j];
        #1;
        chk("t4_stall_valid", ov7 === 1'b1);
        held = odat7; helds = osort7;
        for (int c = 0; c < 4; c++) begin
          chk("t4_stall_in_ready", ird7 === 1'b0);
          idat7 = ~bd[j];
          tick();
          idat7 = bd[j];
          chk("t4_stall_hold_data", odat7 === held);
          chk("t4_stall_hold_sorted", osort7 === helds);
        end
        ordy7 = 1'b1;
      end
      send7(bd[j], br[j]);
    end
    drain();
    tick();

    send7(56'h01_02_03_04_05_06_07, 3'd1);
    send7(56'h11_12_13_14_15_16_17, 3'd2);
    send7(56'h21_22_23_24_25_26_27, 3'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid_after_rst", ov7 === 1'b0);
    chk("t5_data_after_rst", odat7 === 8'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      seen = seen | ov7;
    end
    chk("t5_no_stale_beat", seen === 1'b0);
    send7({8'd6, 8'd5, 8'd40, 8'd30, 8'd2, 8'd1, 8'd0}, 3'd3);
    wait_ov7(n);
    chk("t5_latency", n == 6);
    chk("t5_out_data", odat7 === 8'd5);
    tick();

    for (int k = 0; k < 400; k++) begin
      ivb = 1'($urandom); idatb = {16'($urandom), $urandom}; irankb = 2'($urandom);
      ordyb = ($urandom_range(0, 3) != 0);
      ivc = 1'($urandom); idatc = 2'($urandom); irankc = 1'($urandom);
      ordyc = ($urandom_range(0, 3) != 0);
      tick();
    end
    ivb = 0; ivc = 0; ordyb = 1; ordyc = 1;
    drain();
    tick();
    chk("end_all_idle", {ov7, ovb, ovc} === 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
